// File: rtl/tt_pll_loop_ctrl.sv
// tt_pll_loop_ctrl: PLL digital loop controller.
// Turns PFD up/down pulses into a DCO control word. A SAR coarse search runs first,
// followed by +/-1 fine tracking with lock and unlock detection. The control word
// sits on the scan chain, and a scan shift freezes the rest of the loop.
module tt_pll_loop_ctrl #(
    parameter int CW_W       = 8,
    parameter int WIN_LEN    = 32,
    parameter int LOCK_TOL   = 1,
    parameter int LOCK_WIN   = 16,
    parameter int UNLOCK_TOL = 4
) (
    input  logic            i_clk_gen,
    input  logic            i_rst_n,
    input  logic            i_enable,
    input  logic            i_up,
    input  logic            i_down,
    output logic [CW_W-1:0] o_ctrl_word,
    output logic            o_locked,
    output logic [1:0]      o_state,
    input  logic            i_scan_en,
    input  logic            i_scan_in,
    output logic            o_scan_out
);

    localparam int WC_W  = $clog2(WIN_LEN);
    localparam int NET_W = WC_W + 2;
    localparam int IDX_W = $clog2(CW_W);
    localparam int LC_W  = $clog2(LOCK_WIN + 1);

    localparam logic [CW_W-1:0]         MID     = {1'b1, {(CW_W-1){1'b0}}};
    localparam logic signed [NET_W-1:0] NET_MAX = {1'b0, {(NET_W-1){1'b1}}};
    localparam logic signed [NET_W-1:0] NET_MIN = -NET_MAX;
    localparam logic signed [NET_W-1:0] NET_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COARSE = 2'd1,
        S_FINE   = 2'd2,
        S_LOCKED = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [CW_W-1:0]         word_q, word_d;
    logic                    locked_q, locked_d;
    logic [WC_W-1:0]         wcnt_q, wcnt_d;
    logic signed [NET_W-1:0] net_q, net_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [LC_W-1:0]         lcnt_q, lcnt_d;

    logic signed [NET_W-1:0] net_now;
    logic [NET_W-1:0]        net_abs;
    logic                    net_neg, net_pos, win_end, balanced, unbalanced;

    // Window accumulator including this cycle's pulse; the range is symmetric so |net| never overflows.
    always_comb begin
        net_now = net_q;
        if (i_up && !i_down && net_q != NET_MAX) begin
            net_now = net_q + NET_ONE;
        end else if (i_down && !i_up && net_q != NET_MIN) begin
            net_now = net_q - NET_ONE;
        end
    end

    assign net_neg    = net_now[NET_W-1];
    assign net_pos    = !net_neg && (net_now != '0);
    assign net_abs    = net_neg ? -net_now : net_now;
    assign win_end    = (wcnt_q == WC_W'(WIN_LEN - 1));
    assign balanced   = (net_abs <= NET_W'(LOCK_TOL));
    assign unbalanced = (net_abs > NET_W'(UNLOCK_TOL));

    // Next-state logic: scan shift first, then enable drop, then per-state window decisions.
    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        locked_d = locked_q;
        wcnt_d   = wcnt_q;
        net_d    = net_q;
        idx_d    = idx_q;
        lcnt_d   = lcnt_q;
        if (i_scan_en) begin
            word_d = {word_q[CW_W-2:0], i_scan_in};
        end else if (state_q != S_IDLE && !i_enable) begin
            state_d  = S_IDLE;
            word_d   = MID;
            locked_d = 1'b0;
            wcnt_d   = '0;
            net_d    = '0;
            idx_d    = '0;
            lcnt_d   = '0;
        end else if (state_q == S_IDLE) begin
            word_d   = MID;
            locked_d = 1'b0;
            wcnt_d   = '0;
            net_d    = '0;
            lcnt_d   = '0;
            if (i_enable) begin
                state_d = S_COARSE;
                idx_d   = IDX_W'(CW_W - 1);
            end
        end else begin
            wcnt_d = win_end ? '0 : wcnt_q + 1'b1;
            net_d  = win_end ? '0 : net_now;
            if (win_end) begin
                if (state_q == S_COARSE) begin
                    if (net_neg) begin
                        word_d[idx_q] = 1'b0;
                    end
                    if (idx_q != '0) begin
                        word_d[idx_q - 1'b1] = 1'b1;
                        idx_d                = idx_q - 1'b1;
                    end else begin
                        state_d = S_FINE;
                        lcnt_d  = '0;
                    end
                end else begin
                    if (net_pos && word_q != '1) begin
                        word_d = word_q + 1'b1;
                    end else if (net_neg && word_q != '0) begin
                        word_d = word_q - 1'b1;
                    end
                    if (state_q == S_FINE) begin
                        if (balanced) begin
                            lcnt_d = (lcnt_q >= LC_W'(LOCK_WIN)) ? lcnt_q : lcnt_q + 1'b1;
                        end else begin
                            lcnt_d = '0;
                        end
                        if (lcnt_d == LC_W'(LOCK_WIN)) begin
                            state_d  = S_LOCKED;
                            locked_d = 1'b1;
                        end
                    end else if (unbalanced) begin
                        state_d  = S_FINE;
                        locked_d = 1'b0;
                        lcnt_d   = '0;
                    end
                end
            end
        end
    end

    // State and datapath registers with asynchronous reset to the idle/mid-scale point.
    always_ff @(posedge i_clk_gen or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            word_q   <= MID;
            locked_q <= 1'b0;
            wcnt_q   <= '0;
            net_q    <= '0;
            idx_q    <= '0;
            lcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            locked_q <= locked_d;
            wcnt_q   <= wcnt_d;
            net_q    <= net_d;
            idx_q    <= idx_d;
            lcnt_q   <= lcnt_d;
        end
    end

    assign o_ctrl_word = word_q;
    assign o_locked    = locked_q;
    assign o_state     = state_q;
    assign o_scan_out  = word_q[CW_W-1];

endmodule

// File: tb/tb_tt_pll_loop_ctrl.sv
// tb_tt_pll_loop_ctrl: directed bench for the PLL loop controller.
// Expected values are queued as each step is driven and checked when the step completes.
module tb_tt_pll_loop_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, en, up, down, scan_en, scan_in;
    logic [7:0] word;
    logic       locked, scan_out;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        int         sel;
        logic [7:0] exp;
    } exp_t;

    exp_t sbq[$];

    tt_pll_loop_ctrl #(
        .CW_W(8), .WIN_LEN(32), .LOCK_TOL(1), .LOCK_WIN(16), .UNLOCK_TOL(4)
    ) dut (
        .i_clk_gen  (clk),
        .i_rst_n    (rst_n),
        .i_enable   (en),
        .i_up       (up),
        .i_down     (down),
        .o_ctrl_word(word),
        .o_locked   (locked),
        .o_state    (state),
        .i_scan_en  (scan_en),
        .i_scan_in  (scan_in),
        .o_scan_out (scan_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] obs(input int sel);
        case (sel)
            0:       return word;
            1:       return {6'b0, state};
            2:       return {7'b0, locked};
            default: return {7'b0, scan_out};
        endcase
    endfunction

    task automatic push_exp(input string tag, input int sel, input logic [7:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sbq.push_back(e);
    endtask

    task automatic push3(input string tag, input logic [7:0] w, input logic [1:0] s, input logic l);
        push_exp({tag, "_word"}, 0, w);
        push_exp({tag, "_state"}, 1, {6'b0, s});
        push_exp({tag, "_locked"}, 2, {7'b0, l});
    endtask

    task automatic check_all();
        exp_t       e;
        logic [7:0] o;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            o = obs(e.sel);
            checks++;
            assert (o === e.exp) else begin
                errors++;
                $error("FAIL %s: observed=%0h expected=%0h", e.tag, o, e.exp);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // DCO stand-in: speed up below 0x5A, slow down above it.
    task automatic run_model(input int n);
        repeat (n) begin
            up   = (word < 8'h5A);
            down = (word > 8'h5A);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [7:0] pat, old;
        rst_n = 1'b0; en = 1'b0; up = 1'b0; down = 1'b0; scan_en = 1'b0; scan_in = 1'b0;
        pat = 8'hA5;
        old = 8'h5B;

        step(2);
        push3("reset", 8'h80, 2'd0, 1'b0);
        check_all();
        rst_n = 1'b1;
        step(4);
        push3("idle", 8'h80, 2'd0, 1'b0);
        check_all();

        // All up: SAR keeps every bit, fine tracking saturates at 0xFF.
        en = 1'b1; up = 1'b1;
        step(33);
        push3("up_win1", 8'hC0, 2'd1, 1'b0);
        check_all();
        step(223);
        push_exp("up_before_fine_state", 1, 8'd1);
        check_all();
        step(1);
        push3("up_fine", 8'hFF, 2'd2, 1'b0);
        check_all();
        step(96);
        push3("up_nowrap", 8'hFF, 2'd2, 1'b0);
        check_all();

        en = 1'b0; up = 1'b0;
        step(1);
        push3("fine_disable", 8'h80, 2'd0, 1'b0);
        check_all();

        // All down: SAR clears every bit, fine tracking holds 0x00.
        en = 1'b1; down = 1'b1;
        step(33);
        push3("dn_win1", 8'h40, 2'd1, 1'b0);
        check_all();
        step(224);
        push3("dn_fine", 8'h00, 2'd2, 1'b0);
        check_all();
        step(96);
        push3("dn_nounder", 8'h00, 2'd2, 1'b0);
        check_all();

        // Asynchronous reset mid-cycle while in FINE.
        #2 rst_n = 1'b0;
        #1;
        push3("async_rst", 8'h80, 2'd0, 1'b0);
        check_all();
        en = 1'b0; down = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(5);
        push3("rst_release_idle", 8'h80, 2'd0, 1'b0);
        check_all();

        // Closed loop toward 0x5A: SAR lands on it, then 16 balanced windows lock.
        en = 1'b1;
        run_model(257);
        push3("lock_coarse_end", 8'h5A, 2'd2, 1'b0);
        check_all();
        run_model(511);
        push3("lock_not_yet", 8'h5A, 2'd2, 1'b0);
        check_all();
        run_model(1);
        push3("locked", 8'h5A, 2'd3, 1'b1);
        check_all();

        // Eight up pulses in one window breaks lock at that window end.
        up = 1'b1; down = 1'b0;
        step(8);
        up = 1'b0;
        step(23);
        push3("unlock_before", 8'h5A, 2'd3, 1'b1);
        check_all();
        step(1);
        push3("unlock", 8'h5B, 2'd2, 1'b0);
        check_all();

        // Scan 0xA5 in five cycles into a FINE window; the window must resume where it stopped.
        run_model(5);
        up = 1'b1; down = 1'b0;
        scan_en = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            scan_in = pat[i];
            push_exp("scan_out_bit", 3, {7'b0, old[i]});
            check_all();
            step(1);
        end
        scan_en = 1'b0;
        push3("scan_word", 8'hA5, 2'd2, 1'b0);
        check_all();
        run_model(26);
        push3("scan_frozen_win", 8'hA5, 2'd2, 1'b0);
        check_all();
        run_model(1);
        push3("scan_resume_end", 8'hA4, 2'd2, 1'b0);
        check_all();

        // Simultaneous up and down nets to zero, so the tested bit is kept.
        en = 1'b0; up = 1'b0; down = 1'b0;
        step(1);
        push3("dis2", 8'h80, 2'd0, 1'b0);
        check_all();
        en = 1'b1; up = 1'b1; down = 1'b1;
        step(33);
        push3("both_win1", 8'hC0, 2'd1, 1'b0);
        check_all();
        step(10);
        en = 1'b0;
        step(1);
        push3("coarse_disable", 8'h80, 2'd0, 1'b0);
        check_all();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
